// File: rtl/rib_pkg.sv
// Shared RIB bus definitions.
//   - bus address / data widths
//   - region offset width (low address bits decoded by a slave)
//   - responder FSM state encoding
//   - value returned for an out-of-range read
package rib_pkg;

  localparam int unsigned RIB_ADDR_W = 32;
  localparam int unsigned RIB_DATA_W = 32;
  localparam int unsigned RIB_OFF_W  = 28;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } slv_state_e;

  localparam logic [RIB_DATA_W-1:0] RIB_OOR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/rib_slv_mem.sv
// Word SRAM behind the RIB responder.
//   - DEPTH x 32 storage
//   - asynchronous read, synchronous write
//   - no reset, so contents survive a bus reset
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
module rib_slv_mem
  import rib_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [RIB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [RIB_DATA_W-1:0] rdata
);

  logic [RIB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rib_sram_slave.sv
// RIB responder backed by a word SRAM, with configurable wait states.
// Each access holds the master for WAIT_CYCLES cycles via hold_o, then
// completes in the following cycle (read data valid / write commits there).
// WAIT_CYCLES = 0 gives a single-cycle access with combinational read.
// Optional feature (macro RIB_SLV_BOUND_CHK_EN): out-of-range accesses
// read 0, drop writes and set the sticky err_o flag; otherwise the word
// index wraps modulo DEPTH and err_o is 0.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-low reset
//   req_i  : access request
//   we_i   : 1 = write, 0 = read
//   addr_i : byte address (offset bits [27:0] decoded)
//   data_i : write data
//   data_o : read data, 0 outside a read completion
//   hold_o : stall request while the access is pending
//   err_o  : sticky out-of-range flag
module rib_sram_slave
  import rib_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [RIB_ADDR_W-1:0] addr_i,
  input  logic [RIB_DATA_W-1:0] data_i,
  output logic [RIB_DATA_W-1:0] data_o,
  output logic                  hold_o,
  output logic                  err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]      idx;
  logic [RIB_DATA_W-1:0] mem_rdata;
  logic [RIB_DATA_W-1:0] rd_val;
  logic                  mem_we;
  logic                  oor;
  logic                  err_set;
  logic                  active;
  logic                  unused_bits;

  assign idx = addr_i[IDX_W+1:2];

  // Qualifying the request with rst keeps hold_o/data_o low and blocks any
  // write while reset is asserted, even if the master still drives req_i.
  assign active = req_i & rst;

  assign rd_val = oor ? RIB_OOR_RDATA : mem_rdata;

  assign unused_bits = ^{addr_i, err_set};

  rib_slv_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(idx),
    .wdata(data_i),
    .raddr(idx),
    .rdata(mem_rdata)
  );

  generate
    if (WAIT_CYCLES == 0) begin : g_zero_wait
      assign hold_o  = 1'b0;
      assign data_o  = (active && !we_i) ? rd_val : '0;
      assign mem_we  = active & we_i & ~oor;
      assign err_set = active & oor;
    end else begin : g_wait
      localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

      slv_state_e            state_q, state_d;
      logic [CNT_W-1:0]      cnt_q, cnt_d;
      logic [RIB_DATA_W-1:0] rdata_q, rdata_d;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          rdata_q <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          rdata_q <= rdata_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        hold_o  = 1'b0;
        data_o  = '0;
        mem_we  = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
          ST_IDLE: begin
            if (active) begin
              hold_o  = 1'b1;
              cnt_d   = CNT_INIT;
              rdata_d = rd_val;
              state_d = ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (!active) begin
              state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
              hold_o = 1'b1;
              cnt_d  = cnt_q - 1'b1;
            end else begin
              data_o  = we_i ? '0 : rdata_q;
              mem_we  = we_i & ~oor;
              err_set = oor;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  endgenerate

`ifdef RIB_SLV_BOUND_CHK_EN
  localparam logic [RIB_OFF_W:0] OFF_LIMIT = (RIB_OFF_W + 1)'(DEPTH * 4);

  logic err_q;

  assign oor = ({1'b0, addr_i[RIB_OFF_W-1:0]} >= OFF_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign oor   = 1'b0;
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rib_sram_slave.sv
module tb_rib_sram_slave;

  localparam int unsigned WAITS  [4] = '{2, 0, 3, 2};
  localparam int unsigned DEPTHS [4] = '{4096, 4096, 4096, 16};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       req = '0;
  logic [3:0]       we = '0;
  logic [3:0]       hold;
  logic [3:0]       err;
  logic [3:0][31:0] addr = '0;
  logic [3:0][31:0] wdata = '0;
  logic [3:0][31:0] rdata;

  int total = 0;
  int bad = 0;

  logic [31:0] mdl [int];
  logic [3:0]  err_m = '0;

  always #5 clk = ~clk;

  rib_sram_slave #(.DEPTH(4096), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .data_i(wdata[0]), .data_o(rdata[0]), .hold_o(hold[0]), .err_o(err[0]));
  rib_sram_slave #(.DEPTH(4096), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .data_i(wdata[1]), .data_o(rdata[1]), .hold_o(hold[1]), .err_o(err[1]));
  rib_sram_slave #(.DEPTH(4096), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
    .data_i(wdata[2]), .data_o(rdata[2]), .hold_o(hold[2]), .err_o(err[2]));
  rib_sram_slave #(.DEPTH(16), .WAIT_CYCLES(2)) dut3 (
    .clk(clk), .rst(rst), .req_i(req[3]), .we_i(we[3]), .addr_i(addr[3]),
    .data_i(wdata[3]), .data_o(rdata[3]), .hold_o(hold[3]), .err_o(err[3]));

  function automatic int key_of(input int k, input logic [31:0] a);
    int unsigned off;
    off = {4'b0, a[27:0]};
    return k * 65536 + int'((off >> 2) % DEPTHS[k]);
  endfunction

  function automatic logic oor_m(input int k, input logic [31:0] a);
`ifdef RIB_SLV_BOUND_CHK_EN
    int unsigned off;
    off = {4'b0, a[27:0]};
    return off >= DEPTHS[k] * 4;
`else
    return (k < 0);
`endif
  endfunction

  // One complete transaction: WAIT hold cycles then the completion cycle.
  task automatic access(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int          key;
    logic        ob;
    logic [31:0] exp_rd;
    logic [31:0] exp_d;
    key = key_of(k, a);
    ob  = oor_m(k, a);
    exp_rd = (ob || !mdl.exists(key)) ? 32'h0 : mdl[key];
    for (int c = 0; c <= int'(WAITS[k]); c++) begin
      @(negedge clk);
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
      #1;
      total++;
      if (hold[k] !== (c < int'(WAITS[k]))) begin
        bad++;
        $display("FAIL %s hold dut=%0d cyc=%0d got=%b exp=%b", tag, k, c, hold[k], c < int'(WAITS[k]));
      end
      exp_d = (c == int'(WAITS[k]) && !w) ? exp_rd : 32'h0;
      total++;
      if (rdata[k] !== exp_d) begin
        bad++;
        $display("FAIL %s data dut=%0d cyc=%0d got=%h exp=%h", tag, k, c, rdata[k], exp_d);
      end
      total++;
      if (err[k] !== err_m[k]) begin
        bad++;
        $display("FAIL %s err dut=%0d cyc=%0d got=%b exp=%b", tag, k, c, err[k], err_m[k]);
      end
    end
    if (w && !ob) mdl[key] = d;
    if (ob) err_m[k] = 1'b1;
  endtask

  // Request dropped after n hold cycles (n == WAIT drops it at completion).
  task automatic abort_access(input int k, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
      #1;
      total++;
      if (hold[k] !== 1'b1) begin
        bad++;
        $display("FAIL %s abort_hold dut=%0d cyc=%0d got=%b exp=1", tag, k, c, hold[k]);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req[k] = 1'b0;
      #1;
      total++;
      if (hold[k] !== 1'b0 || rdata[k] !== 32'h0) begin
        bad++;
        $display("FAIL %s abort_idle dut=%0d cyc=%0d got hold=%b data=%h exp hold=0 data=0", tag, k, c, hold[k], rdata[k]);
      end
    end
  endtask

  task automatic idle(input int k, input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      req[k] = 1'b0; we[k] = $urandom_range(0, 1); addr[k] = $urandom;
      #1;
      total++;
      if (hold[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== err_m[k]) begin
        bad++;
        $display("FAIL %s idle dut=%0d got hold=%b data=%h err=%b exp hold=0 data=0 err=%b",
                 tag, k, hold[k], rdata[k], err[k], err_m[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '1; we = '0;
    for (int k = 0; k < 4; k++) addr[k] = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (hold[k] !== 1'b0) begin bad++; $display("FAIL reset_hold dut=%0d got=%b exp=0", k, hold[k]); end
      total++;
      if (rdata[k] !== 32'h0) begin bad++; $display("FAIL reset_data dut=%0d got=%h exp=0", k, rdata[k]); end
      total++;
      if (err[k] !== 1'b0) begin bad++; $display("FAIL reset_err dut=%0d got=%b exp=0", k, err[k]); end
    end
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    err_m = '0;
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 32'h0000_0010, 32'hA5A5_1234, "wr_w2");
    idle(0, 1, "wr_w2");
    access(0, 1'b0, 32'h0000_0010, 32'h0, "rd_w2");
    idle(0, 2, "rd_w2");
  endtask

  task automatic test_zero_wait();
    access(1, 1'b1, 32'h0000_0008, 32'h0000_0001, "wr_w0");
    access(1, 1'b0, 32'h0000_0008, 32'h0, "rd_w0");
    idle(1, 1, "w0");
    access(1, 1'b0, 32'h0000_000B, 32'h0, "rd_w0_lsb");
    idle(1, 1, "w0");
  endtask

  task automatic test_abort();
    access(2, 1'b1, 32'h0000_0010, 32'h0000_0005, "ab_init");
    idle(2, 1, "ab");
    abort_access(2, 1'b0, 32'h0000_0010, 32'h0, 1, "ab_rd");
    abort_access(2, 1'b1, 32'h0000_0010, 32'h0000_0007, 2, "ab_wr2");
    abort_access(2, 1'b1, 32'h0000_0010, 32'h0000_0007, 3, "ab_wr3");
    access(2, 1'b0, 32'h0000_0010, 32'h0, "ab_check");
    idle(2, 1, "ab");
  endtask

  task automatic test_reset_mid_wait();
    access(0, 1'b1, 32'h0000_0004, 32'h1111_2222, "rst_init");
    idle(0, 1, "rst");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'hDEAD_0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (hold[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid got hold=%b data=%h exp hold=0 data=0", hold[0], rdata[0]);
    end
    @(negedge clk);
    #1;
    total++;
    if (hold[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_hold2 got=%b exp=0", hold[0]); end
    req[0] = 1'b0;
    rst = 1'b1;
    err_m = '0;
    idle(0, 1, "rst");
    access(0, 1'b0, 32'h0000_0004, 32'h0, "rst_old");
    idle(0, 1, "rst");
  endtask

  task automatic test_back_to_back();
    access(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, "b2b_init0");
    access(0, 1'b1, 32'h0000_0004, 32'h1234_5678, "b2b_init1");
    access(0, 1'b0, 32'h0000_0000, 32'h0, "b2b_rd0");
    access(0, 1'b0, 32'h0000_0004, 32'h0, "b2b_rd1");
    idle(0, 2, "b2b");
  endtask

  task automatic test_bound();
    access(3, 1'b1, 32'h0000_0000, 32'hCAFE_0001, "bnd_init");
    access(3, 1'b0, 32'h0000_0040, 32'h0, "bnd_rd");
    idle(3, 3, "bnd");
    access(3, 1'b1, 32'h0000_0044, 32'h7777_7777, "bnd_wr");
    access(3, 1'b0, 32'h0000_0004, 32'h0, "bnd_chk");
    idle(3, 2, "bnd");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int unsigned nwords = (k == 3) ? 16 : 8;
      for (int unsigned i = 0; i < nwords; i++)
        access(k, 1'b1, i * 4, $urandom, "rnd_fill");
      for (int i = 0; i < 30; i++) begin
        logic [31:0] a;
        logic        w;
        int unsigned sel;
        w = $urandom_range(0, 1);
        sel = $urandom_range(0, 7);
        if (k == 3) a = {4'($urandom), 24'h0, 4'($urandom_range(0, 7)), 2'($urandom)} & 32'hF000_007F;
        else a = {4'($urandom), 21'h0, 5'($urandom_range(0, 7)), 2'($urandom)};
        if (sel == 0 && WAITS[k] > 0)
          abort_access(k, w, a, $urandom, $urandom_range(1, WAITS[k]), "rnd_abort");
        else
          access(k, w, a, $urandom, "rnd");
        if ($urandom_range(0, 2) == 0) idle(k, 1, "rnd");
      end
      idle(k, 1, "rnd_end");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_bound();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rib_sram_slave.md
Name: rib_sram_slave

Overview:
- Responder (slave) end of the RIB bus: serves the core's data-port requests (`req`/`we`/`addr`/`data`) from an internal word SRAM.
- Models a multi-cycle memory by asserting `hold_o`, which the bus forwards to the core's `rib_hold_flag_i`.
- Gives the team a wait-state-accurate memory slave, to exercise pipeline hold paths that zero-latency RAM never triggers.

Parameters:
- DEPTH, 4096, number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 2, number of `hold_o` cycles per access; 0 = single-cycle access with combinational read.
- IDX_W, $clog2(DEPTH), localparam; word-index width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- req_i  input  1  access request from bus master
- we_i  input  1  1 = write, 0 = read; qualified by req_i
- addr_i  input  32  byte address; only the region offset addr_i[27:0] is used
- data_i  input  32  write data
- data_o  output  32  read data
- hold_o  output  1  stall request to master while access pending
- err_o  output  1  sticky out-of-range flag (optional feature)

Behaviour:
- Word index = addr_i[IDX_W+1:2]; addr_i[1:0] ignored; full-word accesses only (master does read-modify-write for sub-word stores).
- Master holds req_i/we_i/addr_i/data_i stable while hold_o=1.
- WAIT_CYCLES==0:
  - No FSM activity; hold_o=0 always.
  - Read: data_o = mem[idx] combinationally when req_i & !we_i, else 0.
  - Write: commits at the rising edge while req_i & we_i.
- WAIT_CYCLES>0, FSM states IDLE, WAIT:
  - IDLE, req_i=1: hold_o=1 combinationally; cnt<=WAIT_CYCLES-1; rdata_q<=mem[idx]; go WAIT.
  - IDLE, req_i=0: hold_o=0, data_o=0.
  - WAIT, cnt!=0: hold_o=1; cnt<=cnt-1.
  - WAIT, cnt==0: hold_o=0 (completion cycle); data_o=rdata_q if read; write commits at this edge; go IDLE.
  - Total hold cycles per access = WAIT_CYCLES exactly; completion cycle follows.
- data_o is 0 in every cycle that is not a read completion.
- Abort: req_i deasserting in WAIT → return to IDLE, hold_o=0, no write, data_o=0.
- Back-to-back: req_i high in the cycle after completion starts a new transaction, evaluated again from IDLE.
- Reset (any time, including mid-WAIT):
  - state=IDLE, cnt=0, rdata_q=0, hold_o=0, data_o=0, err_o=0.
  - Memory contents are not reset.
  - A pending write is dropped.

Optional Feature:
- Macro: RIB_SLV_BOUND_CHK_EN.
- Defined:
  - Out-of-range access is addr_i[27:0] >= DEPTH*4.
  - Read returns 32'h0.
  - Write is dropped.
  - err_o set at the completion edge, sticky until reset.
  - Timing (hold cycles) identical to a legal access.
- Undefined: index wraps modulo DEPTH; err_o tied to 0.

Decomposition:
- Shared package rib_pkg holds:
  - RIB address/data widths (32).
  - Region offset width (28).
  - FSM state encoding (IDLE/WAIT).
  - Out-of-range read value (32'h0).
- Natural sub-module: rib_slv_mem.
  - DEPTH x 32, one read port, one write port.
  - Asynchronous read, synchronous write, no reset.
  - Top level keeps the FSM, counter and bound check.

Test Plan:
- WAIT_CYCLES=2, write 0xA5A5_1234 to 0x0000_0010, then read 0x0000_0010 → 2 hold cycles each; read completion cycle data_o=0xA5A5_1234; data_o=0 in all other cycles.
- WAIT_CYCLES=0, write 0x1 to 0x8 then read 0x8 → hold_o never asserts; data_o=0x1 in the same cycle as the read req.
- WAIT_CYCLES=3, read issued, req_i dropped after 1 hold cycle; then read 0x10 with prior content 0x5 and a same-address write of 0x7 aborted → FSM in IDLE, hold_o=0; later read of 0x10 returns 0x5.
- Write 0xDEAD_0000 to 0x4 in progress, rst pulsed low mid-WAIT → hold_o=0, data_o=0 immediately; subsequent read of 0x4 returns the old value.
- Back-to-back reads of 0x0 then 0x4 with req_i held high, WAIT_CYCLES=2 → hold pattern 1,1,0,1,1,0 with correct data at each completion.
- RIB_SLV_BOUND_CHK_EN, DEPTH=16, read 0x40 → data_o=0 and err_o=1 from the next cycle, sticky; without the macro, read 0x40 returns the contents of 0x0.
